// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the UART byte receiver: line levels, frame width
// and receiver state encoding.
package uart_rx_byte_pkg;

   localparam logic UART_LINE_IDLE = 1'b1;
   localparam int   UART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      ST_BREAK = 2'd0,
      ST_IDLE  = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_rx_byte_fifo.sv
// Show-ahead output FIFO for received bytes. A push into a full FIFO is
// accepted only when a pop frees a slot at the same edge.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [PTR_W:0]   count_d;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

   assign dout = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver: samples one bit per clock, assembles LSB-first data,
// checks the stop bit and queues good bytes for a valid/ready consumer.
//
// state | meaning
// BREAK | line held low or after error; wait for idle level before framing
// IDLE  | line idle; a low sample is a start bit
// DATA  | shifting in data bits, LSB first
// STOP  | sampling stop bit; high pushes the byte, low flags a framing error
module uart_rx_byte
   import uart_rx_byte_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 signal,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int               CNT_W    = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   rx_state_e            state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 frame_err_q;
   logic                 overrun_q;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 push;
   logic                 pop;

   assign push       = reset && (state_q == ST_STOP) && (signal == UART_LINE_IDLE);
   assign data_valid = !fifo_empty;
   assign pop        = data_valid && data_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_BREAK;
         cnt_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         // A same-edge pop frees the slot, so only an unrelieved full FIFO drops.
         overrun_q   <= push && fifo_full && !pop;
         case (state_q)
            ST_BREAK: begin
               if (signal == UART_LINE_IDLE) state_q <= ST_IDLE;
            end
            ST_IDLE: begin
               if (signal != UART_LINE_IDLE) begin
                  state_q <= ST_DATA;
                  cnt_q   <= '0;
               end
            end
            ST_DATA: begin
               shift_q <= {signal, shift_q[DATA_BITS-1:1]};
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST_BIT) state_q <= ST_STOP;
            end
            ST_STOP: begin
               if (signal == UART_LINE_IDLE) begin
                  state_q <= ST_IDLE;
               end else begin
                  frame_err_q <= 1'b1;
                  state_q     <= ST_BREAK;
               end
            end
            default: state_q <= ST_BREAK;
         endcase
      end
   end

   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (shift_q),
      .pop   (pop),
      .dout  (data_out),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: directed frames, a queue-based reference of the
// receive FIFO checked every cycle, plus literal spot checks.
module tb_uart_rx_byte;

   localparam int DEPTH   = 4;
   localparam int EV_NONE = 0;
   localparam int EV_PUSH = 1;
   localparam int EV_FERR = 2;

   logic       clk        = 1'b0;
   logic       reset      = 1'b0;
   logic       signal     = 1'b1;
   logic       data_ready = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       overrun;

   uart_rx_byte #(
      .DATA_BITS  (8),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .signal     (signal),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // What the stimulus says happens to the line at the coming edge.
   int         ev_kind = EV_NONE;
   logic [7:0] ev_byte = 8'h00;

   logic [7:0] mq[$];
   logic       e_ferr  = 1'b0;
   logic       e_ovr   = 1'b0;
   bit         started = 1'b0;
   bit         m_pop;
   bit         m_full;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      started = 1'b1;
      if (!reset) begin
         mq.delete();
         e_ferr = 1'b0;
         e_ovr  = 1'b0;
      end else begin
         m_pop  = (mq.size() != 0) && data_ready;
         m_full = (mq.size() == DEPTH);
         e_ferr = (ev_kind == EV_FERR);
         e_ovr  = 1'b0;
         if (m_pop) void'(mq.pop_front());
         if (ev_kind == EV_PUSH) begin
            if (m_full && !m_pop) e_ovr = 1'b1;
            else mq.push_back(ev_byte);
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("valid", {31'd0, data_valid}, {31'd0, mq.size() != 0});
         if (mq.size() != 0) chk("data_out", {24'd0, data_out}, {24'd0, mq[0]});
         chk("frame_err", {31'd0, frame_err}, {31'd0, e_ferr});
         chk("overrun", {31'd0, overrun}, {31'd0, e_ovr});
      end
   end

   task automatic drive(input logic v, input int kind, input logic [7:0] b, input logic rdy);
      @(negedge clk);
      signal     = v;
      ev_kind    = kind;
      ev_byte    = b;
      data_ready = rdy;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1, EV_NONE, 8'h00, 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input logic rdy_stop);
      drive(1'b0, EV_NONE, 8'h00, 1'b0);
      for (int i = 0; i < 8; i++) drive(b[i], EV_NONE, 8'h00, 1'b0);
      drive(stop, stop ? EV_PUSH : EV_FERR, b, rdy_stop);
   endtask

   // Bytes packed little-end: v[7:0] is the first expected head.
   task automatic drain(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, EV_NONE, 8'h00, 1'b1);
         chk("drain_valid", {31'd0, data_valid}, 32'd1);
         chk("drain_head", {24'd0, data_out}, {24'd0, v[8*i +: 8]});
      end
      drive(1'b1, EV_NONE, 8'h00, 1'b0);
      chk("drain_empty", {31'd0, data_valid}, 32'd0);
   endtask

   initial begin
      // 1: reset, idle line, frame 0xA5
      idle(2);
      reset = 1'b1;
      chk("rst_valid", {31'd0, data_valid}, 32'd0);
      chk("rst_data", {24'd0, data_out}, 32'h0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_ovr", {31'd0, overrun}, 32'd0);
      idle(3);
      send_frame(8'hA5, 1'b1, 1'b0);
      idle(1);
      chk("a5_valid", {31'd0, data_valid}, 32'd1);
      chk("a5_data", {24'd0, data_out}, 32'hA5);
      chk("a5_ferr", {31'd0, frame_err}, 32'd0);
      drain(32'h000000A5, 1);

      // 2: bad stop, long low run, then a good frame
      send_frame(8'h3C, 1'b0, 1'b0);
      drive(1'b0, EV_NONE, 8'h00, 1'b0);
      chk("ferr_pulse", {31'd0, frame_err}, 32'd1);
      chk("ferr_nopush", {31'd0, data_valid}, 32'd0);
      drive(1'b0, EV_NONE, 8'h00, 1'b0);
      chk("ferr_once", {31'd0, frame_err}, 32'd0);
      repeat (3) drive(1'b0, EV_NONE, 8'h00, 1'b0);
      chk("low_run_quiet", {31'd0, data_valid}, 32'd0);
      idle(1);
      send_frame(8'h11, 1'b1, 1'b0);
      idle(1);
      chk("x11_data", {24'd0, data_out}, 32'h11);
      drain(32'h00000011, 1);

      // 3: back-to-back frames, then drain on consecutive cycles
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      send_frame(8'h80, 1'b1, 1'b0);
      idle(1);
      chk("b2b_valid", {31'd0, data_valid}, 32'd1);
      drain(32'h0080FF00, 3);

      // 4: five frames into a four-deep FIFO
      for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b0);
      idle(1);
      chk("ovr_pulse", {31'd0, overrun}, 32'd1);
      idle(1);
      chk("ovr_once", {31'd0, overrun}, 32'd0);
      drain(32'h04030201, 4);

      // 5: full FIFO relieved by a pop at the 5th stop edge
      for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 1'b0);
      send_frame(8'h05, 1'b1, 1'b1);
      idle(1);
      chk("pop_no_ovr", {31'd0, overrun}, 32'd0);
      chk("pop_head", {24'd0, data_out}, 32'h02);
      drain(32'h05040302, 4);

      // 6: reset in the middle of a frame
      send_frame(8'h77, 1'b1, 1'b0);
      idle(1);
      chk("pre_rst_valid", {31'd0, data_valid}, 32'd1);
      drive(1'b0, EV_NONE, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) drive(((8'h5A >> i) & 8'h01) != 0, EV_NONE, 8'h00, 1'b0);
      drive(1'b1, EV_NONE, 8'h00, 1'b0);
      reset = 1'b0;
      drive(1'b1, EV_NONE, 8'h00, 1'b0);
      reset = 1'b1;
      chk("mid_rst_empty", {31'd0, data_valid}, 32'd0);
      chk("mid_rst_data", {24'd0, data_out}, 32'h0);
      idle(2);
      chk("abort_no_valid", {31'd0, data_valid}, 32'd0);
      send_frame(8'h5A, 1'b1, 1'b0);
      idle(1);
      chk("x5a_data", {24'd0, data_out}, 32'h5A);
      drain(32'h0000005A, 1);

      idle(2);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
